// File: rtl/display_pkg.sv
// Shared constants for the BCD 7-segment display path: active-low glyphs,
// logical position numbering and the decimal digit table.
package display_pkg;

  localparam int NUM_ANODES = 4;
  localparam logic [2:0] POS_SIGN = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ERR   = 7'h06;

  // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit.
  function automatic logic [6:0] seg_digit(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_ERR;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph selection for one display slot.
// Priority: error glyph, then minus, then blank, then the decimal digit.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_minus,
  input  logic       i_err,
  output logic [6:0] o_seg
);

  // Glyph priority mux.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_err) begin
      o_seg = SEG_ERR;
    end else if (i_minus) begin
      o_seg = SEG_MINUS;
    end else if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = seg_digit(i_nibble);
    end
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 4-anode display of a signed 5-digit BCD value through a
// scrollable window over positions D1..D5 and sign.
module bcd_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_OFFSET  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] bcd_in,
  input  logic        sign_in,
  input  logic        load,
  input  logic        scroll_l,
  input  logic        scroll_r,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_scan;
  logic [2:0]       r_offset;
  logic [19:0]      r_value;
  logic             r_sign;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_tick;
  logic [2:0]       w_pos;
  logic [3:0]       w_nibble;
  logic             w_lead_zero;
  logic             w_blank;
  logic             w_minus;
  logic             w_err;
  logic [6:0]       w_seg;

  assign w_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_pos  = r_offset + {1'b0, r_scan};

  // Nibble select and "this digit and everything above it is zero" flag.
  always_comb begin
    w_nibble    = 4'd0;
    w_lead_zero = 1'b0;
    case (w_pos)
      3'd0: begin
        w_nibble    = r_value[3:0];
        w_lead_zero = 1'b0;
      end
      3'd1: begin
        w_nibble    = r_value[7:4];
        w_lead_zero = (r_value[19:4] == 16'd0);
      end
      3'd2: begin
        w_nibble    = r_value[11:8];
        w_lead_zero = (r_value[19:8] == 12'd0);
      end
      3'd3: begin
        w_nibble    = r_value[15:12];
        w_lead_zero = (r_value[19:12] == 8'd0);
      end
      3'd4: begin
        w_nibble    = r_value[19:16];
        w_lead_zero = (r_value[19:16] == 4'd0);
      end
      default: begin
        w_nibble    = 4'd0;
        w_lead_zero = 1'b0;
      end
    endcase
  end

  // Slot flags; positions past the sign show blank.
  always_comb begin
    w_err   = 1'b0;
    w_minus = 1'b0;
    w_blank = 1'b0;
    if (w_pos < POS_SIGN) begin
      w_err   = (w_nibble > 4'd9);
      w_blank = w_lead_zero;
    end else if (w_pos == POS_SIGN) begin
      w_minus = r_sign && (r_value != 20'd0);
      w_blank = 1'b1;
    end else begin
      w_blank = 1'b1;
    end
  end

  seg7_decoder u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .i_minus  (w_minus),
    .i_err    (w_err),
    .o_seg    (w_seg)
  );

  // Refresh counter and scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_scan <= 2'd0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_scan <= r_scan + 2'd1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_scan <= r_scan;
    end
  end

  // Capture registers for value and sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 20'd0;
      r_sign  <= 1'b0;
    end else if (load) begin
      r_value <= bcd_in;
      r_sign  <= sign_in;
    end else begin
      r_value <= r_value;
      r_sign  <= r_sign;
    end
  end

  // Saturating window offset; opposing pulses cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset <= 3'd0;
    end else begin
      case ({scroll_l, scroll_r})
        2'b10: begin
          if (r_offset < 3'(MAX_OFFSET)) r_offset <= r_offset + 3'd1;
          else                           r_offset <= r_offset;
        end
        2'b01: begin
          if (r_offset > 3'd0) r_offset <= r_offset - 3'd1;
          else                 r_offset <= r_offset;
        end
        default: r_offset <= r_offset;
      endcase
    end
  end

  // Output registers: anode and segments update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_scan);
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Sequential 7-segment display driver downstream of the binary-to-BCD stage; consumes the 5-digit BCD result and its sign bit.
- Time-multiplexes a 4-digit common-anode display across 6 logical positions (D1..D5 plus sign) through a scrollable 4-position window.
- Provides leading-zero blanking, minus-sign display and an error glyph for invalid BCD nibbles.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit); minimum 2.
- MAX_OFFSET, 2, highest window offset (6 positions minus 4 anodes).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bcd_in  in  20  BCD value; [3:0]=D1 (units) .. [19:16]=D5
- sign_in  in  1  1 = negative
- load  in  1  capture bcd_in/sign_in this edge
- scroll_l  in  1  single-cycle pulse (pre-debounced): offset +1
- scroll_r  in  1  single-cycle pulse: offset -1
- an  out  4  anode enables, active-low one-hot
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low, always 1

Behaviour:
- Reset: an=4'hF, seg=7'h7F, dp=1, latched value=0, latched sign=0, offset=0, refresh counter=0, scan index=0.
- Refresh: counter runs 0..REFRESH_DIV-1 and wraps. tick=1 when counter==REFRESH_DIV-1. On tick, scan index increments mod 4 (3 wraps to 0).
- Logical positions: 0..4 = D1..D5, 5 = sign. Anode k (k=0 rightmost) shows position offset+k.
- Outputs are registered. an/seg at edge n+1 reflect scan index, latched data and offset as held after edge n; an and seg always change on the same edge.
- an = ~(1<<scan index); exactly one anode is low after reset.
- Load: on load=1, value and sign are captured at that edge; offset is unchanged. Displayed one cycle later per the output rule.
- Scroll:
  - scroll_l alone: offset+1, saturating at MAX_OFFSET.
  - scroll_r alone: offset-1, saturating at 0.
  - Both in the same cycle: no change.
  - Scroll with load in the same cycle: both take effect.
- Digit glyph for position p<5:
  - If nibble>9: 'E' = 7'h06.
  - Else if p>0 and all nibbles p..4 are zero: blank 7'h7F (leading-zero blanking; D1 is never blanked).
  - Else decimal code: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Sign position: minus 7'h3F if sign=1 and value is nonzero; otherwise blank 7'h7F (no "-0"). An invalid nibble counts as nonzero.
- Reset mid-scan: the next edge returns everything to reset values. Scanning restarts at anode 0 on the first cycle after rst deasserts.
- No combinational path from any input to an/seg/dp.

Decomposition:
- Shared package display_pkg holds:
  - segment constants SEG_BLANK, SEG_MINUS, SEG_ERR and the digit table;
  - POS_SIGN=5;
  - NUM_ANODES=4.
- Sub-module seg7_decoder (combinational): 4-bit nibble plus blank/minus/err flags in, 7-bit active-low seg out.
- Top holds the refresh counter, scan index, offset register, capture registers and output registers.

Test Plan (REFRESH_DIV=4):
- Reset and release -> an=4'hE (anode 0), seg=7'h7F before any load. With rst held for 10 cycles, an stays 4'hF and seg stays 7'h7F.
- load bcd 20'h15625, sign 0, offset 0 -> over four slots: an 4'hE/D/B/7 with seg 12/24/02/12 (5,2,6,5); each slot lasts 4 cycles.
- scroll_l pulsed 3 times -> offset saturates at 2; anodes 0..3 show 6,5,1,blank = 02/12/79/7F. Then scroll_l+scroll_r in the same cycle -> offset stays 2.
- load 20'h15625, sign 1, offset 2 -> anode 3 shows 7'h3F. Then load 20'h00000, sign 1 -> anode 3 shows 7'h7F, anode 0..2 blank, and D1 at offset 0 shows 7'h40.
- load 20'h00042, sign 0, offset 0 -> 2,4,blank,blank = 24/19/7F/7F. Then load 20'h0000A -> anode 0 shows 7'h06 and anodes 1..3 show blank.
- Assert rst mid-scan at scan index 2 with offset 2 -> next edge an=4'hF, seg=7'h7F; after release, offset=0 and the scan restarts at anode 0.
